// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/stop/lap/clear sequencer for a 4-digit BCD stopwatch.
//               Optional macro STOPWATCH_WRAP_EN: roll over 9999->0000
//               instead of entering the sticky overflow state.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DIV = 10,
    parameter int W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ss_n,
    input  logic         lap_n,
    input  logic         at_max,
    input  logic [W-1:0] cnt_bcd,
    output logic         cnt_en,
    output logic         cnt_clr,
    output logic [W-1:0] disp_bcd,
    output logic         running,
    output logic         ovf,
    output logic [2:0]   state
);

    localparam int                    c_PCNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_PCNT_W-1:0]   c_PCNT_MAX = c_PCNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STOP = 3'd2,
        S_LAP  = 3'd3,
        S_OVF  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_ss_prev;
    logic                r_lap_prev;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic                r_tick;
    logic [W-1:0]        r_lap_reg;
    logic                r_ovf;
    logic                r_clr_pulse;

    logic w_ss_ev;
    logic w_lap_ev;
    logic w_live;
    logic w_hit;
    logic w_adv;

    // Start/stop has priority: a simultaneous lap press is discarded.
    assign w_ss_ev  = r_ss_prev & ~ss_n;
    assign w_lap_ev = r_lap_prev & ~lap_n & ~w_ss_ev;
    assign w_live   = (r_state == S_RUN) || (r_state == S_LAP);

`ifdef STOPWATCH_WRAP_EN
    assign w_hit  = 1'b0;
    assign cnt_en = r_tick & w_live & ~rst;
    assign ovf    = r_ovf | (r_tick & w_live & at_max & ~rst);
`else
    assign w_hit  = r_tick & w_live & at_max;
    assign cnt_en = r_tick & w_live & ~at_max & ~rst;
    assign ovf    = r_ovf;
`endif

    // The prescaler only advances on edges that stay in RUN/LAP, so a stop
    // freezes the phase exactly where the press found it.
    assign w_adv = w_live & ~w_ss_ev & ~w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ss_prev   <= 1'b1;
            r_lap_prev  <= 1'b1;
            r_pcnt      <= '0;
            r_tick      <= 1'b0;
            r_lap_reg   <= '0;
            r_ovf       <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_ss_prev   <= ss_n;
            r_lap_prev  <= lap_n;
            r_clr_pulse <= 1'b0;
            r_tick      <= 1'b0;

            if (w_adv) begin
                if (r_pcnt == c_PCNT_MAX) begin
                    r_pcnt <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end else if ((r_state == S_IDLE) || (r_state == S_OVF)) begin
                r_pcnt <= '0;
            end

            if (w_hit) begin
                r_state <= S_OVF;
                r_ovf   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ss_ev) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_ss_ev) begin
                            r_state <= S_STOP;
                        end else if (w_lap_ev) begin
                            r_state   <= S_LAP;
                            r_lap_reg <= cnt_bcd;
                        end
                    end
                    S_LAP: begin
                        if (w_ss_ev)       r_state <= S_STOP;
                        else if (w_lap_ev) r_state <= S_RUN;
                    end
                    S_STOP: begin
                        if (w_ss_ev) begin
                            r_state <= S_RUN;
                        end else if (w_lap_ev) begin
                            r_state     <= S_IDLE;
                            r_ovf       <= 1'b0;
                            r_clr_pulse <= 1'b1;
                        end
                    end
                    S_OVF: begin
                        if (w_lap_ev) begin
                            r_state     <= S_IDLE;
                            r_ovf       <= 1'b0;
                            r_clr_pulse <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cnt_clr  = rst | r_clr_pulse;
    assign running  = w_live;
    assign state    = r_state;
    assign disp_bcd = (r_state == S_LAP) ? r_lap_reg : cnt_bcd;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl with a decimal
//               datapath model and a mode/phase reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam int W   = 16;
`ifdef STOPWATCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3, M_OVF = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ss_n = 1'b1;
    logic         lap_n = 1'b1;
    logic         at_max;
    logic [W-1:0] cnt_bcd;
    logic         cnt_en;
    logic         cnt_clr;
    logic [W-1:0] disp_bcd;
    logic         running;
    logic         ovf;
    logic [2:0]   state;

    stopwatch_ctrl #(.DIV(DIV), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .lap_n    (lap_n),
        .at_max   (at_max),
        .cnt_bcd  (cnt_bcd),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .disp_bcd (disp_bcd),
        .running  (running),
        .ovf      (ovf),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Decimal datapath stand-in: an integer 0..9999 shown as packed BCD.
    int dp_val = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign cnt_bcd = to_bcd(dp_val);
    assign at_max  = (dp_val == 9999);

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, total edges spent counting, lap snapshot.
    int          m_mode = M_IDLE;
    int          m_run  = 0;
    logic [15:0] m_lap  = '0;
    bit          m_tick = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_clr  = 1'b0;
    bit          m_pss  = 1'b1;
    bit          m_plap = 1'b1;
    bit          s_en   = 1'b0;
    bit          s_clr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ss_ev, lap_ev, live, nlive, hit;
        int nm;
        if (rst) begin
            m_mode = M_IDLE; m_run = 0; m_tick = 0; m_lap = '0;
            m_ovf = 0; m_clr = 0; m_pss = 1; m_plap = 1;
            return;
        end
        ss_ev  = m_pss && !ss_n;
        lap_ev = m_plap && !lap_n && !ss_ev;
        live   = (m_mode == M_RUN) || (m_mode == M_LAP);
        hit    = live && m_tick && at_max && !WRAP;
        nm     = m_mode;
        if (hit) nm = M_OVF;
        else case (m_mode)
            M_IDLE: if (ss_ev) nm = M_RUN;
            M_RUN:  if (ss_ev) nm = M_STOP; else if (lap_ev) nm = M_LAP;
            M_LAP:  if (ss_ev) nm = M_STOP; else if (lap_ev) nm = M_RUN;
            M_STOP: if (ss_ev) nm = M_RUN;  else if (lap_ev) nm = M_IDLE;
            default: if (lap_ev) nm = M_IDLE;
        endcase
        m_clr = lap_ev && (m_mode == M_STOP || m_mode == M_OVF);
        if (m_mode == M_RUN && nm == M_LAP) m_lap = cnt_bcd;
        nlive  = (nm == M_RUN) || (nm == M_LAP);
        m_tick = 0;
        if (live && nlive) begin
            m_run++;
            m_tick = ((m_run % DIV) == 0);
        end else if (nm == M_IDLE || nm == M_OVF) begin
            m_run = 0;
        end
        if (nm == M_IDLE && m_mode != M_IDLE) m_ovf = 0;
        if (hit) m_ovf = 1;
        m_mode = nm;
        m_pss  = ss_n;
        m_plap = lap_n;
    endtask

    task automatic compare_outputs();
        bit live;
        live = (m_mode == M_RUN) || (m_mode == M_LAP);
        chk("state",    state,    m_mode[2:0]);
        chk("running",  running,  live);
        chk("cnt_en",   cnt_en,   !rst && m_tick && live && !(at_max && !WRAP));
        chk("cnt_clr",  cnt_clr,  rst || m_clr);
        chk("ovf",      ovf,      WRAP ? (!rst && m_tick && live && at_max) : m_ovf);
        chk("disp_bcd", disp_bcd, (m_mode == M_LAP) ? m_lap : cnt_bcd);
        s_en  = cnt_en;
        s_clr = cnt_clr;
    endtask

    // One clock: drive inputs, let the edge happen, move datapath, compare.
    task automatic step(input bit r, input bit s, input bit l);
        rst = r; ss_n = s; lap_n = l;
        @(posedge clk);
        model_step();
        #1;
        if (s_clr)     dp_val = 0;
        else if (s_en) dp_val = (dp_val + 1) % 10000;
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        bit found;

        step(1, 1, 1);
        step(1, 1, 1);
        chk("rst_state", state, 3'd0);
        chk("rst_clr", cnt_clr, 1'b1);
        chk("rst_en", cnt_en, 1'b0);
        chk("rst_running", running, 1'b0);
        step(0, 1, 1);
        chk("post_rst_clr", cnt_clr, 1'b0);

        // Start: ticks land DIV, 2*DIV, 3*DIV cycles after the press.
        step(0, 0, 1);
        chk("start_running", running, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 1);
            chk("tick_phase", cnt_en, (k % 4) == 0);
        end

        // Lap freeze while the count advances underneath.
        step(0, 1, 1);
        dp_val = 123;
        step(0, 1, 0);
        chk("lap_state", state, 3'd3);
        chk("lap_disp0", disp_bcd, 16'h0123);
        repeat (7) step(0, 1, 1);
        chk("lap_disp_hold", disp_bcd, 16'h0123);
        step(0, 1, 0);
        chk("unlap_state", state, 3'd1);
        chk("unlap_disp", disp_bcd, 16'h0125);

        // Stop with prescaler at 2, resume keeps phase.
        step(0, 0, 1);
        chk("stop_state", state, 3'd2);
        repeat (3) begin
            step(0, 1, 1);
            chk("stop_no_en", cnt_en, 1'b0);
        end
        step(0, 0, 1);
        chk("resume_en0", cnt_en, 1'b0);
        step(0, 1, 1);
        chk("resume_en1", cnt_en, 1'b0);
        step(0, 1, 1);
        chk("resume_en2", cnt_en, 1'b1);

        // Clear from STOP; simultaneous presses from STOP resume.
        step(0, 0, 1);
        step(0, 1, 0);
        chk("clear_state", state, 3'd0);
        chk("clear_pulse", cnt_clr, 1'b1);
        chk("clear_ovf", ovf, 1'b0);
        step(0, 1, 1);
        chk("clear_once", cnt_clr, 1'b0);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);
        chk("both_state", state, 3'd1);
        chk("both_noclr", cnt_clr, 1'b0);

        // Overflow at 9999.
        step(0, 1, 1);
        if (m_tick) step(0, 1, 1);
        dp_val = 9999;
        found = 1'b0;
        for (int i = 0; i < 3 * DIV && !found; i++) begin
            step(0, 1, 1);
            found = m_tick;
        end
        chk("ovf_tick_seen", found, 1'b1);
`ifdef STOPWATCH_WRAP_EN
        chk("wrap_en", cnt_en, 1'b1);
        chk("wrap_ovf", ovf, 1'b1);
        step(0, 1, 1);
        chk("wrap_state", state, 3'd1);
        chk("wrap_ovf_drop", ovf, 1'b0);
`else
        chk("ovf_en", cnt_en, 1'b0);
        step(0, 1, 1);
        chk("ovf_state", state, 3'd4);
        chk("ovf_flag", ovf, 1'b1);
        step(0, 0, 1);
        chk("ovf_ss_ignored", state, 3'd4);
        step(0, 1, 0);
        chk("ovf_clear_state", state, 3'd0);
        chk("ovf_clear_pulse", cnt_clr, 1'b1);
        chk("ovf_clear_flag", ovf, 1'b0);
        step(0, 0, 1);
`endif
        // Reset while in LAP.
        step(0, 1, 1);
        step(0, 1, 0);
        chk("lap2_state", state, 3'd3);
        step(1, 1, 1);
        chk("rst_lap_state", state, 3'd0);
        chk("rst_lap_disp", disp_bcd, cnt_bcd);
        step(0, 1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0));
            if (!s_en && !s_clr && $urandom_range(0, 149) == 0)
                dp_val = 9990 + int'($urandom_range(0, 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
